// File: rtl/vdu_mem_arbiter.sv
// Display RAM arbiter: shares one single-port synchronous RAM between the VDU
// character fetch port (fixed 1-cycle latency, always wins) and the CPU bus.
module vdu_mem_arbiter #(
  parameter logic [15:0] BASE_ADDR = 16'h0200,
  parameter int unsigned MEM_AW    = 9
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  input  logic              vdu_read_en,
  input  logic [15:0]       vdu_read_addr,
  output logic [7:0]        vdu_display_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ack;
  logic [7:0]        r_rdata;
  logic [7:0]        r_vdu_hold;
  logic              r_vdu_rd_d1;
  logic              r_we;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_wdata;

  logic [15:0]       w_cpu_diff;
  logic              w_cpu_in_win;
  logic [MEM_AW-1:0] w_vdu_off;
  logic              w_accept;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of the window.
  assign w_cpu_diff   = cpu_addr - BASE_ADDR;
  assign w_cpu_in_win = (w_cpu_diff[15:MEM_AW] == '0);
  assign w_vdu_off    = MEM_AW'(vdu_read_addr - BASE_ADDR);
  assign w_accept     = cpu_req && !r_ack && (r_state == ST_IDLE);

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_cpu_in_win ? ST_WAIT : ST_ERR;
        end
      end
      ST_WAIT: begin
        if (!vdu_read_en) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vdu_read_en) begin
      mem_addr = w_vdu_off;
    end else if (r_state == ST_WAIT) begin
      mem_addr  = r_addr;
      mem_we    = r_we;
      mem_wdata = r_wdata;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= cpu_we;
      r_addr  <= w_cpu_diff[MEM_AW-1:0];
      r_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= (r_state == ST_RESP) || (r_state == ST_ERR);
      if (r_state == ST_ERR) begin
        r_rdata <= '1;
      end else if ((r_state == ST_RESP) && !r_we) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      r_vdu_rd_d1 <= 1'b0;
      r_vdu_hold  <= '0;
    end else begin
      r_vdu_rd_d1 <= vdu_read_en;
      if (r_vdu_rd_d1) begin
        r_vdu_hold <= mem_rdata;
      end
    end
  end

  assign vdu_display_data = r_vdu_rd_d1 ? mem_rdata : r_vdu_hold;
  assign cpu_ack          = r_ack;
  assign cpu_rdata        = r_rdata;

endmodule

// File: tb/tb_vdu_mem_arbiter.sv
// Directed bench for vdu_mem_arbiter with a behavioural single-port RAM
// (1-cycle read latency) attached to the mem_* port.
module tb_vdu_mem_arbiter;

  logic        clk_pix = 1'b0;
  logic        rst_pix_n;
  logic        vdu_read_en;
  logic [15:0] vdu_read_addr;
  logic [7:0]  vdu_display_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [512];
  int          n_checks = 0;
  int          n_fail   = 0;

  vdu_mem_arbiter #(
    .BASE_ADDR(16'h0200),
    .MEM_AW   (9)
  ) dut (
    .clk_pix         (clk_pix),
    .rst_pix_n       (rst_pix_n),
    .vdu_read_en     (vdu_read_en),
    .vdu_read_addr   (vdu_read_addr),
    .vdu_display_data(vdu_display_data),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_ack         (cpu_ack),
    .cpu_rdata       (cpu_rdata),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic test_reset();
    rst_pix_n = 1'b0;
    step();
    step();
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", cpu_ack); end
    n_checks++;
    if (cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", cpu_rdata); end
    n_checks++;
    if (vdu_display_data !== 8'h00) begin n_fail++; $display("FAIL reset_vdu: got %h expected 00", vdu_display_data); end
    n_checks++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    step();
    rst_pix_n = 1'b1;
  endtask

  task automatic test_cpu_write_read();
    // cycle 0: request, cycle 1: issue, cycle 2: RESP, cycle 3: ack
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'hA5;
    step();
    @(negedge clk_pix);
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 9'h000 || mem_wdata !== 8'hA5) begin
      n_fail++; $display("FAIL wr_issue: got we=%b addr=%h wdata=%h expected 1/000/a5", mem_we, mem_addr, mem_wdata);
    end
    step();
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp: got ack=%b we=%b expected 0/0", cpu_ack, mem_we);
    end
    step();
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b expected 1", cpu_ack); end
    // req still high across the ack edge must not start a new access
    step();
    cpu_req = 1'b0;
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_reissue: got ack=%b we=%b expected 0/0", cpu_ack, mem_we);
    end
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    step();
    @(negedge clk_pix);
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== 9'h000) begin
      n_fail++; $display("FAIL rd_issue: got we=%b addr=%h expected 0/000", mem_we, mem_addr);
    end
    step();
    step();
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL rd_ack: got ack=%b rdata=%h expected 1/a5", cpu_ack, cpu_rdata);
    end
    step();
    cpu_req = 1'b0;
    vdu_read_en = 1'b1; vdu_read_addr = 16'h0200;
    step();
    vdu_read_en = 1'b0;
    @(negedge clk_pix);
    n_checks++;
    if (vdu_display_data !== 8'hA5) begin n_fail++; $display("FAIL raw_vdu: got %h expected a5", vdu_display_data); end
    step();
    @(negedge clk_pix);
    n_checks++;
    if (vdu_display_data !== 8'hA5) begin n_fail++; $display("FAIL raw_vdu_hold: got %h expected a5", vdu_display_data); end
  endtask

  task automatic test_vdu_stream();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    for (int i = 0; i < 19; i++) begin
      step();
      if (i < 16) begin
        vdu_read_en = 1'b1; vdu_read_addr = 16'h0200 + 16'(i);
      end else begin
        vdu_read_en = 1'b0;
      end
      @(negedge clk_pix);
      if (i >= 1) begin
        exp = (i <= 16) ? 8'(i - 1) : 8'h0F;
        n_checks++;
        if (vdu_display_data !== exp) begin
          n_fail++; $display("FAIL stream[%0d]: got %h expected %h", i, vdu_display_data, exp);
        end
      end
    end
  endtask

  task automatic test_contention();
    int c;
    ram[9'h1FF] = 8'h3C;
    for (int k = 0; k < 10; k++) ram[9'h020 + k] = 8'h80 + 8'(k);
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h03FF;
    for (int k = 1; k <= 10; k++) begin
      step();
      vdu_read_en = 1'b1; vdu_read_addr = 16'h0220 + 16'(k - 1);
      @(negedge clk_pix);
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== 9'h020 + 9'(k - 1)) begin
        n_fail++; $display("FAIL cont_mux[%0d]: got we=%b addr=%h expected 0/%h", k, mem_we, mem_addr, 9'h020 + 9'(k - 1));
      end
      if (k >= 2) begin
        n_checks++;
        if (vdu_display_data !== 8'h80 + 8'(k - 2)) begin
          n_fail++; $display("FAIL cont_vdu[%0d]: got %h expected %h", k, vdu_display_data, 8'h80 + 8'(k - 2));
        end
      end
    end
    step();
    vdu_read_en = 1'b0;
    @(negedge clk_pix);
    n_checks++;
    if (mem_addr !== 9'h1FF || mem_we !== 1'b0 || vdu_display_data !== 8'h89) begin
      n_fail++; $display("FAIL cont_issue: got addr=%h we=%b vdu=%h expected 1ff/0/89", mem_addr, mem_we, vdu_display_data);
    end
    c = 11;
    do begin
      step();
      c++;
      @(negedge clk_pix);
    end while (cpu_ack !== 1'b1 && c < 40);
    n_checks++;
    if (c !== 13) begin n_fail++; $display("FAIL cont_latency: got ack in cycle %0d expected 13", c); end
    n_checks++;
    if (cpu_rdata !== 8'h3C || vdu_display_data !== 8'h89) begin
      n_fail++; $display("FAIL cont_data: got rdata=%h vdu=%h expected 3c/89", cpu_rdata, vdu_display_data);
    end
    step();
    cpu_req = 1'b0;
  endtask

  task automatic test_out_of_window();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
    step();
    @(negedge clk_pix);
    n_checks++;
    if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL oow_rd_c1: got we=%b ack=%b expected 0/0", mem_we, cpu_ack);
    end
    step();
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hFF) begin
      n_fail++; $display("FAIL oow_rd_ack: got ack=%b rdata=%h expected 1/ff", cpu_ack, cpu_rdata);
    end
    step();
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h5A;
    step();
    @(negedge clk_pix);
    n_checks++;
    if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
      n_fail++; $display("FAIL oow_wr_c1: got we=%b ack=%b expected 0/0", mem_we, cpu_ack);
    end
    step();
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL oow_wr_ack: got ack=%b we=%b expected 1/0", cpu_ack, mem_we);
    end
    step();
    cpu_req = 1'b0;
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL oow_wr_done: got ack=%b we=%b expected 0/0", cpu_ack, mem_we);
    end
  endtask

  task automatic test_reset_mid_op();
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0205; cpu_wdata = 8'h77;
    step();
    vdu_read_en = 1'b1; vdu_read_addr = 16'h0200;
    rst_pix_n = 1'b0;
    @(negedge clk_pix);
    n_checks++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_vdu_prio: got we=%b expected 0", mem_we); end
    step();
    rst_pix_n = 1'b1; cpu_req = 1'b0; vdu_read_en = 1'b0;
    @(negedge clk_pix);
    n_checks++;
    if (cpu_rdata !== 8'h00 || vdu_display_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_regs: got rdata=%h vdu=%h expected 00/00", cpu_rdata, vdu_display_data);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      @(negedge clk_pix);
      n_checks++;
      if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_quiet[%0d]: got we=%b ack=%b expected 0/0", k, mem_we, cpu_ack);
      end
    end
    n_checks++;
    if (ram[5] !== 8'h05) begin n_fail++; $display("FAIL rst_mid_ram: got %h expected 05", ram[5]); end
    step();
    cpu_req = 1'b1;
    step();
    @(negedge clk_pix);
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 9'h005 || mem_wdata !== 8'h77) begin
      n_fail++; $display("FAIL reissue_issue: got we=%b addr=%h wdata=%h expected 1/005/77", mem_we, mem_addr, mem_wdata);
    end
    step();
    step();
    @(negedge clk_pix);
    n_checks++;
    if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL reissue_ack: got %b expected 1", cpu_ack); end
    step();
    cpu_req = 1'b0;
    @(negedge clk_pix);
    n_checks++;
    if (ram[5] !== 8'h77) begin n_fail++; $display("FAIL reissue_ram: got %h expected 77", ram[5]); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    rst_pix_n     = 1'b0;
    vdu_read_en   = 1'b0;
    vdu_read_addr = 16'h0000;
    cpu_req       = 1'b0;
    cpu_we        = 1'b0;
    cpu_addr      = 16'h0000;
    cpu_wdata     = 8'h00;
    test_reset();
    test_cpu_write_read();
    test_vdu_stream();
    test_contention();
    test_out_of_window();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vdu_mem_arbiter.md
Name: vdu_mem_arbiter

Overview:
- Shares one single-port synchronous display RAM between the MK14 CPU bus and the VDU character fetch port.
- Sits directly upstream of the HDMI VDU wrapper and feeds its read_en/read_addr/display_data interface.
- The VDU always has priority and sees a fixed 1-cycle read latency.
- CPU accesses use a req/ack handshake and are stalled while the VDU is fetching.

Parameters:
- BASE_ADDR, 16'h0200, CPU/VDU address of display RAM byte 0.
- MEM_AW, 9, display RAM address width (512 bytes = 16x32 characters).

Ports:
- clk_pix  in  1  pixel clock; all logic on rising edge
- rst_pix_n  in  1  reset; synchronous, active-low
- vdu_read_en  in  1  VDU read strobe
- vdu_read_addr  in  16  VDU byte address
- vdu_display_data  out  8  VDU read data
- cpu_req  in  1  CPU request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  16  CPU byte address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  CPU read data; valid while cpu_ack=1, held afterwards
- mem_addr  out  MEM_AW  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data; 1-cycle latency after mem_addr

Behaviour:
- Reset values, applied while rst_pix_n=0 at a clock edge:
  - state=IDLE, cpu_ack=0, cpu_rdata=8'h00, vdu hold register=8'h00, vdu_rd_d1=0, latched CPU request cleared.
  - A request in flight at reset is dropped; the CPU must re-issue it.
- Address translation: offset = addr - BASE_ADDR, truncated to MEM_AW bits. In-window means 0 <= addr-BASE_ADDR < 2^MEM_AW.
- RAM mux:
  - If vdu_read_en=1: mem_addr = VDU offset, mem_we=0.
  - Else if state=WAIT: mem_addr = latched CPU offset, mem_we = latched we, mem_wdata = latched wdata.
  - Else: mem_we=0, mem_addr = don't-care (drive 0).
- VDU path:
  - vdu_rd_d1 <= vdu_read_en.
  - vdu_display_data = mem_rdata when vdu_rd_d1=1, otherwise the hold register.
  - The hold register captures mem_rdata whenever vdu_rd_d1=1.
  - Latency is exactly 1 cycle. VDU reads may occur back-to-back every cycle and are never stalled.
  - Out-of-window VDU addresses are not checked; the truncated offset is used.
- CPU FSM, states IDLE, WAIT, RESP, plus a registered cpu_ack:
  - IDLE: if cpu_req=1 and cpu_ack=0, latch we/addr/wdata.
    - In-window -> WAIT.
    - Out-of-window -> ERR path: next edge sets cpu_rdata=8'hFF, cpu_ack=1, no RAM access, back to IDLE.
  - cpu_req is ignored while cpu_ack=1, so a request still held in the ack cycle is not re-issued.
  - WAIT: if vdu_read_en=0, the CPU access is issued this cycle -> RESP. Otherwise stay in WAIT with no timeout; the VDU can starve the CPU.
  - RESP: mem_rdata belongs to the CPU access (vdu_rd_d1=0 guaranteed).
    - Read: cpu_rdata <= mem_rdata.
    - Write: cpu_rdata is unchanged.
    - cpu_ack <= 1; state -> IDLE.
  - cpu_ack is high for exactly one cycle and is cleared on the following edge.
- Latency:
  - Uncontended: cpu_req seen at edge 0, issue cycle 1, RESP cycle 2, cpu_ack high in cycle 3.
  - Each cycle of vdu_read_en while in WAIT adds one cycle.
- Simultaneous events:
  - vdu_read_en in the same cycle the CPU would issue: the VDU wins and the CPU stays in WAIT.
  - A CPU write and a VDU read never reach the RAM in the same cycle.
- Read-after-write: a CPU write is visible to any VDU read issued after the write's issue cycle.

Test Plan:
- Reset then idle: rst_pix_n=0 for 2 cycles -> cpu_ack=0, cpu_rdata=8'h00, vdu_display_data=8'h00, mem_we=0.
- Uncontended CPU write then read:
  - Write 8'hA5 to 16'h0200 -> mem_we=1 with mem_addr=0 in cycle 1, cpu_ack in cycle 3.
  - Read 16'h0200 -> cpu_rdata=8'hA5 with cpu_ack.
- VDU streaming: vdu_read_en for 16 consecutive cycles at addresses 16'h0200..16'h020F (RAM preloaded with i) -> vdu_display_data=i one cycle after each strobe; value held after the last strobe.
- Contention:
  - CPU read of 16'h03FF issued while vdu_read_en is held for 10 cycles -> no CPU RAM access during those cycles.
  - cpu_ack arrives 3+10 cycles after the request.
  - VDU data is uncorrupted throughout.
- Out-of-window: CPU read of 16'h0400 and write to 16'h0100 -> cpu_ack after 1 cycle, cpu_rdata=8'hFF for the read, mem_we never asserted.
- Reset mid-operation: assert rst_pix_n=0 while in WAIT -> no cpu_ack, no RAM write afterwards, FSM back in IDLE. A re-issued request completes normally.
